// File: rtl/wnorm_pipe.sv
// Pipelined NUM_G-channel weight normaliser: w_g / sum(w) as a Q_BITS fraction via a restoring divider.
// Optional WNORM_PIPE_ROUND_EN adds a guard-bit stage and rounds to nearest (halves up).
module wnorm_pipe #(
    parameter int NUM_G      = 3,
    parameter int W_WIDTH    = 32,
    parameter int Q_BITS     = 8,
    parameter int SIDE_WIDTH = 291
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [NUM_G*W_WIDTH-1:0]   w_in,
    input  logic [SIDE_WIDTH-1:0]      side_in,
    output logic                       out_valid,
    output logic [NUM_G*W_WIDTH-1:0]   w_norm_out,
    output logic [SIDE_WIDTH-1:0]      side_out,
    output logic                       zero_sum_out
);

    localparam int SUM_W = W_WIDTH + $clog2(NUM_G);
    localparam int RW    = SUM_W + 1;
`ifdef WNORM_PIPE_ROUND_EN
    localparam int NSTEP = Q_BITS + 2;
`else
    localparam int NSTEP = Q_BITS + 1;
`endif
    localparam int LATENCY = NSTEP + 2;
    localparam logic [Q_BITS+1:0] QMAX = (Q_BITS+2)'((1 << Q_BITS) - 1);

    logic [SUM_W-1:0]   sum_in;
    logic               s_valid;
    logic               s_zero;
    logic [SUM_W-1:0]   s_sum;
    logic [W_WIDTH-1:0] s_w [NUM_G];

    logic               d_vld  [NSTEP];
    logic               d_zero [NSTEP];
    logic [SUM_W-1:0]   d_sum  [NSTEP];
    logic [RW-1:0]      d_rem  [NSTEP][NUM_G];
    logic [NSTEP-1:0]   d_quo  [NSTEP][NUM_G];

    logic               in_vld  [NSTEP];
    logic               in_zero [NSTEP];
    logic [SUM_W-1:0]   in_div  [NSTEP];
    logic [RW-1:0]      in_rem  [NSTEP][NUM_G];
    logic [NSTEP-1:0]   in_quo  [NSTEP][NUM_G];
    logic               take    [NSTEP][NUM_G];
    logic [RW-1:0]      nx_rem  [NSTEP][NUM_G];
    logic [NSTEP-1:0]   nx_quo  [NSTEP][NUM_G];

    logic [SIDE_WIDTH-1:0]    side_q [LATENCY-1];
    logic [NUM_G*W_WIDTH-1:0] norm_nx;
    logic [Q_BITS+1:0]        q_full;
    logic [Q_BITS-1:0]        q_sat;

    always_comb begin
        sum_in = '0;
        for (int g = 0; g < NUM_G; g++) begin
            sum_in = sum_in + SUM_W'(w_in[g*W_WIDTH +: W_WIDTH]);
        end
    end

    // Each divider stage takes its inputs from the previous stage; stage 0 starts from the raw weight,
    // later stages double the remainder. A zero divisor suppresses every quotient bit.
    always_comb begin
        in_vld[0]  = s_valid;
        in_zero[0] = s_zero;
        in_div[0]  = s_sum;
        for (int g = 0; g < NUM_G; g++) begin
            in_rem[0][g] = RW'(s_w[g]);
            in_quo[0][g] = '0;
        end
        for (int d = 1; d < NSTEP; d++) begin
            in_vld[d]  = d_vld[d-1];
            in_zero[d] = d_zero[d-1];
            in_div[d]  = d_sum[d-1];
            for (int g = 0; g < NUM_G; g++) begin
                in_rem[d][g] = d_rem[d-1][g] << 1;
                in_quo[d][g] = d_quo[d-1][g];
            end
        end
        for (int d = 0; d < NSTEP; d++) begin
            for (int g = 0; g < NUM_G; g++) begin
                take[d][g]   = !in_zero[d] && (in_rem[d][g] >= RW'(in_div[d]));
                nx_rem[d][g] = take[d][g] ? (in_rem[d][g] - RW'(in_div[d])) : in_rem[d][g];
                nx_quo[d][g] = (in_quo[d][g] << 1) | NSTEP'(take[d][g]);
            end
        end
    end

    always_comb begin
        norm_nx = '0;
        q_full  = '0;
        q_sat   = '0;
        for (int g = 0; g < NUM_G; g++) begin
`ifdef WNORM_PIPE_ROUND_EN
            q_full = (Q_BITS+2)'(d_quo[NSTEP-1][g][NSTEP-1:1]) + (Q_BITS+2)'(d_quo[NSTEP-1][g][0]);
`else
            q_full = (Q_BITS+2)'(d_quo[NSTEP-1][g]);
`endif
            q_sat = (q_full > QMAX) ? '1 : q_full[Q_BITS-1:0];
            if (!d_zero[NSTEP-1]) begin
                norm_nx[g*W_WIDTH +: W_WIDTH] = W_WIDTH'(q_sat) << (W_WIDTH - Q_BITS);
            end
        end
    end

    always_ff @(posedge clk) begin
        s_sum  <= sum_in;
        s_zero <= (sum_in == '0);
        for (int g = 0; g < NUM_G; g++) begin
            s_w[g] <= w_in[g*W_WIDTH +: W_WIDTH];
        end
        for (int d = 0; d < NSTEP; d++) begin
            d_sum[d]  <= in_div[d];
            d_zero[d] <= in_zero[d];
            for (int g = 0; g < NUM_G; g++) begin
                d_rem[d][g] <= nx_rem[d][g];
                d_quo[d][g] <= nx_quo[d][g];
            end
        end
        side_q[0] <= side_in;
        for (int i = 1; i < LATENCY - 1; i++) begin
            side_q[i] <= side_q[i-1];
        end
    end

    // Outputs only load on a valid pixel so they hold between pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid <= 1'b0;
            for (int d = 0; d < NSTEP; d++) begin
                d_vld[d] <= 1'b0;
            end
            out_valid    <= 1'b0;
            w_norm_out   <= '0;
            side_out     <= '0;
            zero_sum_out <= 1'b0;
        end else begin
            s_valid <= in_valid;
            for (int d = 0; d < NSTEP; d++) begin
                d_vld[d] <= in_vld[d];
            end
            out_valid <= d_vld[NSTEP-1];
            if (d_vld[NSTEP-1]) begin
                w_norm_out   <= norm_nx;
                side_out     <= side_q[LATENCY-2];
                zero_sum_out <= d_zero[NSTEP-1];
            end
        end
    end

endmodule
